// File: rtl/rst_seq_monitor.sv
// rtl/rst_seq_monitor.sv - measures assert delay and pulse width of an asynchronous reset line
module rst_seq_monitor #(
    parameter int          CNT_W       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          MON_POL     = 1,
    parameter int unsigned MIN_PULSE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_rst,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_delay,
    output logic [CNT_W-1:0] rpt_duration,
    output logic             rpt_sat,
    output logic             err_glitch,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_P   = MIN_PULSE[CNT_W-1:0];
    localparam logic             MON_ACT = (MON_POL != 0);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        MEAS_LOW,
        MEAS_HIGH
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             wait_cnt;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_sat;
    logic [CNT_W-1:0]       delay_q;
    logic                   delay_sat;
    logic                   mon_act;

    assign mon_act = (sync_q[SYNC_STAGES-1] == MON_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC_WAIT;
            sync_q       <= {SYNC_STAGES{~MON_ACT}};
            wait_cnt     <= 3'd0;
            cnt          <= '0;
            cnt_sat      <= 1'b0;
            delay_q      <= '0;
            delay_sat    <= 1'b0;
            rpt_valid    <= 1'b0;
            rpt_delay    <= '0;
            rpt_duration <= '0;
            rpt_sat      <= 1'b0;
            err_glitch   <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_rst};
            err_glitch <= 1'b0;
            if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            case (state)
                SYNC_WAIT: begin
                    cnt     <= '0;
                    cnt_sat <= 1'b0;
                    if (wait_cnt == 3'(SYNC_STAGES - 1)) begin
                        state <= MEAS_LOW;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                MEAS_LOW: begin
                    if (!mon_act) begin
                        if (cnt == CNT_MAX) cnt_sat <= 1'b1;
                        else                cnt     <= cnt + CNT_W'(1);
                    end else begin
                        delay_q   <= cnt;
                        delay_sat <= cnt_sat;
                        cnt       <= CNT_W'(1);
                        cnt_sat   <= 1'b0;
                        state     <= MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (mon_act) begin
                        if (cnt == CNT_MAX) cnt_sat <= 1'b1;
                        else                cnt     <= cnt + CNT_W'(1);
                    end else begin
                        // The deasserting cycle already counts toward the next delay.
                        cnt     <= CNT_W'(1);
                        cnt_sat <= 1'b0;
                        state   <= MEAS_LOW;
                        if (cnt < MIN_P) begin
                            err_glitch <= 1'b1;
                        end else if (!rpt_valid || rpt_ready) begin
                            rpt_valid    <= 1'b1;
                            rpt_delay    <= delay_q;
                            rpt_duration <= cnt;
                            rpt_sat      <= delay_sat | cnt_sat;
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                end
                default: state <= SYNC_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_monitor.sv
// tb/tb_rst_seq_monitor.sv - self-checking bench for rst_seq_monitor
module tb_rst_seq_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] mon, rdy, v, so, g, o;
    logic [15:0] dl0, du0, dl2, du2;
    logic [3:0]  dl1, du1;

    int checks = 0;
    int errors = 0;

    // inst0 defaults, inst1 narrow counters, inst2 active-low with 3 sync stages
    rst_seq_monitor u0 (
        .clk(clk), .rst(rst), .mon_rst(mon[0]), .rpt_valid(v[0]), .rpt_ready(rdy[0]),
        .rpt_delay(dl0), .rpt_duration(du0), .rpt_sat(so[0]), .err_glitch(g[0]), .err_overrun(o[0]));
    rst_seq_monitor #(.CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .mon_rst(mon[1]), .rpt_valid(v[1]), .rpt_ready(rdy[1]),
        .rpt_delay(dl1), .rpt_duration(du1), .rpt_sat(so[1]), .err_glitch(g[1]), .err_overrun(o[1]));
    rst_seq_monitor #(.MON_POL(0), .SYNC_STAGES(3)) u2 (
        .clk(clk), .rst(rst), .mon_rst(mon[2]), .rpt_valid(v[2]), .rpt_ready(rdy[2]),
        .rpt_delay(dl2), .rpt_duration(du2), .rpt_sat(so[2]), .err_glitch(g[2]), .err_overrun(o[2]));

    function automatic logic [15:0] get_dl(int i);
        if (i == 0) return dl0;
        if (i == 1) return {12'd0, dl1};
        return dl2;
    endfunction

    function automatic logic [15:0] get_du(int i);
        if (i == 0) return du0;
        if (i == 1) return {12'd0, du1};
        return du2;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    // Model: run lengths of the delayed (synchronized) monitor level, in plain integers
    int cw [3] = '{16, 4, 16};
    int ss [3] = '{2, 2, 3};
    bit pol[3] = '{1'b1, 1'b1, 1'b0};
    localparam int MINP = 2;

    int  ph[3], wc[3], lo[3], hi[3], dd[3];
    logic [3:0] hist[3];
    bit  ev[3], es[3], eg[3], eo[3];
    int  ed[3], eu[3];
    int  ncyc = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit act, had_v;
            int mx;
            if (rst) begin
                ph[i] = 0; wc[i] = 0; lo[i] = 0; hi[i] = 0; dd[i] = 0;
                hist[i] = pol[i] ? 4'b0000 : 4'b1111;
                ev[i] = 0; es[i] = 0; eg[i] = 0; eo[i] = 0; ed[i] = 0; eu[i] = 0;
            end else begin
                act   = (hist[i][ss[i]-1] == pol[i]);
                mx    = (1 << cw[i]) - 1;
                had_v = ev[i];
                hist[i] = {hist[i][2:0], mon[i]};
                eg[i] = 0;
                if (had_v && rdy[i]) ev[i] = 0;
                if (ph[i] == 0) begin
                    wc[i]++;
                    if (wc[i] == ss[i]) begin ph[i] = 1; lo[i] = 0; end
                end else if (ph[i] == 1) begin
                    if (!act) lo[i]++;
                    else begin dd[i] = lo[i]; hi[i] = 1; ph[i] = 2; end
                end else begin
                    if (act) hi[i]++;
                    else begin
                        if (hi[i] < MINP) eg[i] = 1;
                        else if (!had_v || rdy[i]) begin
                            ev[i] = 1;
                            ed[i] = (dd[i] > mx) ? mx : dd[i];
                            eu[i] = (hi[i] > mx) ? mx : hi[i];
                            es[i] = (dd[i] > mx) || (hi[i] > mx);
                        end else eo[i] = 1;
                        ph[i] = 1; lo[i] = 1;
                    end
                end
            end
        end
        ncyc++;
    end

    int gcnt[3] = '{0, 0, 0};
    int vcnt[3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (ncyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("rpt_valid",    i, 32'(v[i]),      32'(ev[i]));
                chk("rpt_delay",    i, 32'(get_dl(i)), 32'(ed[i]));
                chk("rpt_duration", i, 32'(get_du(i)), 32'(eu[i]));
                chk("rpt_sat",      i, 32'(so[i]),     32'(es[i]));
                chk("err_glitch",   i, 32'(g[i]),      32'(eg[i]));
                chk("err_overrun",  i, 32'(o[i]),      32'(eo[i]));
                gcnt[i] += int'(g[i]);
                vcnt[i] += int'(v[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, input int bound);
        @(negedge clk);
        for (int k = 0; k < bound && v[i] !== 1'b1; k++) @(negedge clk);
        chk("valid_wait", i, 32'(v[i]), 32'd1);
    endtask

    task automatic chk_rpt(input string nm, input int i, input int d, input int u, input int s);
        chk({nm, "_delay"},    i, 32'(get_dl(i)), 32'(d));
        chk({nm, "_duration"}, i, 32'(get_du(i)), 32'(u));
        chk({nm, "_sat"},      i, 32'(so[i]),     32'(s));
    endtask

    int g_base, v_base;

    initial begin
        rst = 1'b1;
        mon = 3'b100;
        rdy = 3'b111;
        step(3);
        @(negedge clk);
        chk("reset_valid",   0, 32'(v[0]), 32'd0);
        chk("reset_overrun", 0, 32'(o[0]), 32'd0);
        chk("reset_glitch",  0, 32'(g[0]), 32'd0);
        chk_rpt("reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            begin
                step(5);  mon[0] = 1'b1;
                step(10); mon[0] = 1'b0;
                wait_valid(0, 30);
                chk_rpt("basic", 0, 5, 10, 0);
            end
            begin
                step(20); mon[1] = 1'b1;
                step(3);  mon[1] = 1'b0;
                wait_valid(1, 30);
                chk_rpt("sat", 1, 15, 3, 1);
            end
            begin
                step(2); mon[2] = 1'b0;
                step(4); mon[2] = 1'b1;
                wait_valid(2, 30);
                chk_rpt("active_low", 2, 2, 4, 0);
            end
        join
        step(2);

        g_base = gcnt[0];
        v_base = vcnt[0];
        mon[0] = 1'b1; step(1);
        mon[0] = 1'b0; step(10);
        chk("glitch_count", 0, 32'(gcnt[0] - g_base), 32'd1);
        chk("glitch_no_rpt", 0, 32'(vcnt[0] - v_base), 32'd0);

        rdy[0] = 1'b0;
        mon[0] = 1'b1; step(3);
        mon[0] = 1'b0; step(6);
        mon[0] = 1'b1; step(4);
        mon[0] = 1'b0; step(10);
        @(negedge clk);
        chk("held_valid", 0, 32'(v[0]), 32'd1);
        chk_rpt("held", 0, 10, 3, 0);
        chk("overrun_set", 0, 32'(o[0]), 32'd1);
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        step(2);
        chk("drained", 0, 32'(v[0]), 32'd0);
        chk("overrun_sticky", 0, 32'(o[0]), 32'd1);

        mon[0] = 1'b1; step(5);
        rst = 1'b1; step(2);
        @(negedge clk);
        chk("rerst_valid",   0, 32'(v[0]), 32'd0);
        chk("rerst_overrun", 0, 32'(o[0]), 32'd0);
        chk_rpt("rerst", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon[0] = 1'b0;
        step(3); mon[0] = 1'b1;
        step(4); mon[0] = 1'b0;
        wait_valid(0, 30);
        chk_rpt("resync", 0, 3, 4, 0);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
